// File: rtl/otter_pkg.sv
// otter_pkg: shared encodings for the OTTER control unit.
//   alu_fun_t  - ALU operation codes driven on alu_fun
//   opcode_t   - RV32I major opcodes recognised by the decoder
//   state_t    - control FSM states (ST_INIT..ST_INTR = 0..4)
//   SRCA_/SRCB_/PC_/RF_ constants - mux select encodings
//   dec_t      - decoder result handed to the FSM for strobe gating
package otter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_COPYA = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_fun_t;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic       SRCA_RS1  = 1'b0;
  localparam logic       SRCA_UIMM = 1'b1;

  localparam logic [2:0] SRCB_RS2  = 3'd0;
  localparam logic [2:0] SRCB_IIMM = 3'd1;
  localparam logic [2:0] SRCB_SIMM = 3'd2;
  localparam logic [2:0] SRCB_PC   = 3'd3;
  localparam logic [2:0] SRCB_CSR  = 3'd4;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_MEPC   = 3'd5;

  localparam logic [1:0] RF_PC4    = 2'd0;
  localparam logic [1:0] RF_CSR    = 2'd1;
  localparam logic [1:0] RF_MEM    = 2'd2;
  localparam logic [1:0] RF_ALU    = 2'd3;

  localparam logic [31:0] INSTR_MRET = 32'h3020_0073;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic       srca_sel;
    logic [2:0] srcb_sel;
    logic [2:0] pc_sel;
    logic [1:0] rf_wr_sel;
    logic       load;    // needs the WB state
    logic       store;
    logic       rf_wr;
    logic       csr_wr;
    logic       mret;
  } dec_t;

endpackage

// File: rtl/otter_decoder.sv
// otter_decoder: purely combinational decode of the instruction register and
// branch comparator flags into ALU op, operand/PC/writeback selects and
// instruction-class flags. No state, no strobes.
//   ir              in  instruction word
//   br_eq/lt/ltu    in  branch comparator results
//   dec             out decoded fields (dec_t)
// OTTER_INTR_EN: when defined, SYSTEM decodes CSRRW and MRET; otherwise
// SYSTEM falls into the NOP default.
module otter_decoder
  import otter_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       taken;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];

  // 010/011 are not branch encodings and never redirect
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    dec = '0;
    case (opc)
      OPC_OP: begin
        dec.alu_fun   = {ir[30], f3};
        dec.rf_wr_sel = RF_ALU;
        dec.rf_wr     = 1'b1;
      end
      OPC_OPIMM: begin
        // ir[30] is immediate data except for SRAI
        dec.alu_fun   = {ir[30] & (f3 == 3'b101), f3};
        dec.srcb_sel  = SRCB_IIMM;
        dec.rf_wr_sel = RF_ALU;
        dec.rf_wr     = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_fun   = ALU_COPYA;
        dec.srca_sel  = SRCA_UIMM;
        dec.rf_wr_sel = RF_ALU;
        dec.rf_wr     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_fun   = ALU_ADD;
        dec.srca_sel  = SRCA_UIMM;
        dec.srcb_sel  = SRCB_PC;
        dec.rf_wr_sel = RF_ALU;
        dec.rf_wr     = 1'b1;
      end
      OPC_JAL: begin
        dec.pc_sel    = PC_JAL;
        dec.rf_wr_sel = RF_PC4;
        dec.rf_wr     = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_fun   = ALU_ADD;
        dec.srcb_sel  = SRCB_IIMM;
        dec.pc_sel    = PC_JALR;
        dec.rf_wr_sel = RF_PC4;
        dec.rf_wr     = 1'b1;
      end
      OPC_BRANCH: dec.pc_sel = taken ? PC_BRANCH : PC_PLUS4;
      OPC_LOAD: begin
        dec.alu_fun   = ALU_ADD;
        dec.srcb_sel  = SRCB_IIMM;
        dec.rf_wr_sel = RF_MEM;
        dec.load      = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_fun   = ALU_ADD;
        dec.srcb_sel  = SRCB_SIMM;
        dec.store     = 1'b1;
      end
`ifdef OTTER_INTR_EN
      OPC_SYSTEM: begin
        if (ir == INSTR_MRET) begin
          dec.pc_sel = PC_MEPC;
          dec.mret   = 1'b1;
        end else if (f3 == 3'b001) begin
          // CSRRW: rs1 passes through the ALU into the CSR, old CSR to rd
          dec.alu_fun   = ALU_COPYA;
          dec.rf_wr_sel = RF_CSR;
          dec.rf_wr     = 1'b1;
          dec.csr_wr    = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

`ifndef OTTER_INTR_EN
  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
`endif

endmodule

// File: rtl/otter_ctrl_unit.sv
// otter_ctrl_unit: multi-cycle control FSM for the OTTER RV32I core.
// Sequences INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH and gates the
// decoder output into PC/RF/memory/CSR strobes. All outputs are
// combinational from the registered state plus ir, so an async reset
// drops every strobe in the same cycle.
//   clk, rst_n        core clock, async active-low reset
//   ir, br_*          instruction and branch flags
//   intr, mie         interrupt request / enable
//   alu_fun, alu_src*_sel, pc_sel, rf_wr_sel   datapath selects
//   pc_write, rf_write, mem_rden1/2, mem_we2, csr_we, int_taken, mret_exec
// OTTER_INTR_EN: enables interrupt entry, CSRRW and MRET; when undefined
// intr/mie are ignored and csr_we/int_taken/mret_exec stay 0.
module otter_ctrl_unit
  import otter_pkg::*;
#(
  parameter int RST_FETCH_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic        intr,
  input  logic        mie,
  output logic [3:0]  alu_fun,
  output logic        alu_srcA_sel,
  output logic [2:0]  alu_srcB_sel,
  output logic [2:0]  pc_sel,
  output logic [1:0]  rf_wr_sel,
  output logic        pc_write,
  output logic        rf_write,
  output logic        mem_rden1,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic        csr_we,
  output logic        int_taken,
  output logic        mret_exec
);

  state_t     state, nxt;
  logic [1:0] cnt;
  dec_t       dec;
  logic       intr_req;

  otter_decoder u_dec (
    .ir     (ir),
    .br_eq  (br_eq),
    .br_lt  (br_lt),
    .br_ltu (br_ltu),
    .dec    (dec)
  );

`ifdef OTTER_INTR_EN
  assign intr_req = intr & mie;
`else
  logic unused_intr;
  assign intr_req    = 1'b0;
  assign unused_intr = intr ^ mie;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == ST_INIT) ? cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    nxt          = state;
    alu_fun      = ALU_ADD;
    alu_srcA_sel = SRCA_RS1;
    alu_srcB_sel = SRCB_RS2;
    pc_sel       = PC_PLUS4;
    rf_wr_sel    = RF_PC4;
    pc_write     = 1'b0;
    rf_write     = 1'b0;
    mem_rden1    = 1'b0;
    mem_rden2    = 1'b0;
    mem_we2      = 1'b0;
    csr_we       = 1'b0;
    int_taken    = 1'b0;
    mret_exec    = 1'b0;
    case (state)
      ST_INIT: if (cnt == 2'(RST_FETCH_DLY - 1)) nxt = ST_FETCH;
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        nxt       = ST_EXEC;
      end
      ST_EXEC: begin
        alu_fun      = dec.alu_fun;
        alu_srcA_sel = dec.srca_sel;
        alu_srcB_sel = dec.srcb_sel;
        pc_sel       = dec.pc_sel;
        rf_wr_sel    = dec.rf_wr_sel;
        if (dec.load) begin
          // PC holds until WB so the load address stays stable
          mem_rden2 = 1'b1;
          nxt       = ST_WB;
        end else begin
          pc_write = 1'b1;
          rf_write = dec.rf_wr;
          mem_we2  = dec.store;
`ifdef OTTER_INTR_EN
          csr_we    = dec.csr_wr;
          mret_exec = dec.mret;
`endif
          nxt = intr_req ? ST_INTR : ST_FETCH;
        end
      end
      ST_WB: begin
        alu_fun      = dec.alu_fun;
        alu_srcA_sel = dec.srca_sel;
        alu_srcB_sel = dec.srcb_sel;
        pc_sel       = dec.pc_sel;
        rf_wr_sel    = RF_MEM;
        rf_write     = 1'b1;
        pc_write     = 1'b1;
        nxt          = intr_req ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        pc_sel   = PC_MTVEC;
        pc_write = 1'b1;
`ifdef OTTER_INTR_EN
        int_taken = 1'b1;
`endif
        nxt = ST_FETCH;
      end
      default: nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_otter_ctrl_unit.sv
// tb_otter_ctrl_unit: scoreboard bench for otter_ctrl_unit. Expected output
// vectors are hand-built per cycle, queued when stimulus is driven and
// compared on the following falling edge. Covers reset, ALU decode, load
// WB path, branches, JAL, unknown opcode, interrupt entry, SYSTEM decode
// under either OTTER_INTR_EN setting, and reset mid-EXEC.
module tb_otter_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        br_eq, br_lt, br_ltu, intr, mie;
  logic [3:0]  alu_fun;
  logic        alu_srcA_sel;
  logic [2:0]  alu_srcB_sel, pc_sel;
  logic [1:0]  rf_wr_sel;
  logic        pc_write, rf_write, mem_rden1, mem_rden2, mem_we2;
  logic        csr_we, int_taken, mret_exec;

  otter_ctrl_unit #(.RST_FETCH_DLY(1)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .intr(intr), .mie(mie),
    .alu_fun(alu_fun), .alu_srcA_sel(alu_srcA_sel), .alu_srcB_sel(alu_srcB_sel),
    .pc_sel(pc_sel), .rf_wr_sel(rf_wr_sel),
    .pc_write(pc_write), .rf_write(rf_write),
    .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
    .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec)
  );

  always #5 clk = ~clk;

  // strobe byte: pc_write rf_write rden1 rden2 we2 csr_we int_taken mret
  localparam logic [7:0] S_PCW = 8'h80, S_RFW = 8'h40, S_RD1 = 8'h20, S_RD2 = 8'h10;
  localparam logic [7:0] S_WE2 = 8'h08, S_CSR = 8'h04, S_INT = 8'h02, S_MRT = 8'h01;

  logic [20:0] obs;
  assign obs = {alu_fun, alu_srcA_sel, alu_srcB_sel, pc_sel, rf_wr_sel,
                pc_write, rf_write, mem_rden1, mem_rden2, mem_we2,
                csr_we, int_taken, mret_exec};

  function automatic logic [20:0] mk(input logic [3:0] af, input logic a,
                                     input logic [2:0] b, input logic [2:0] pcs,
                                     input logic [1:0] rws, input logic [7:0] s);
    return {af, a, b, pcs, rws, s};
  endfunction

  int n_vec = 0;
  int n_bad = 0;
  logic [20:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  // queue the expected vector for the current cycle, advance one cycle
  task automatic cyc(input string tag, input logic [20:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  logic [20:0] vf;
  task automatic run(input string tag, input logic [31:0] instr, input logic [20:0] ex);
    ir = instr;
    cyc({tag, "_fetch"}, vf);
    cyc({tag, "_exec"}, ex);
  endtask

  initial begin
    vf = mk(4'd0, 1'b0, 3'd0, 3'd0, 2'd0, S_RD1);
    rst_n = 1'b0; ir = '0; br_eq = 0; br_lt = 0; br_ltu = 0; intr = 0; mie = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs, '0);
    rst_n = 1'b1;
    cyc("init", '0);

    run("add",  32'h002081B3, mk(4'b0000, 0, 3'd0, 3'd0, 2'd3, S_PCW | S_RFW));
    run("srai", 32'h4032D293, mk(4'b1101, 0, 3'd1, 3'd0, 2'd3, S_PCW | S_RFW));
    run("sub",  32'h40208133, mk(4'b1000, 0, 3'd0, 3'd0, 2'd3, S_PCW | S_RFW));
    run("addi", 32'h40008093, mk(4'b0000, 0, 3'd1, 3'd0, 2'd3, S_PCW | S_RFW));

    run("lw", 32'h0080A203, mk(4'b0000, 0, 3'd1, 3'd0, 2'd2, S_RD2));
    cyc("lw_wb", mk(4'b0000, 0, 3'd1, 3'd0, 2'd2, S_PCW | S_RFW));

    br_lt = 1'b1;
    run("blt_t", 32'h0020C463, mk(4'd0, 0, 3'd0, 3'd2, 2'd0, S_PCW));
    br_lt = 1'b0;
    run("blt_n", 32'h0020C463, mk(4'd0, 0, 3'd0, 3'd0, 2'd0, S_PCW));
    br_eq = 1'b1;
    run("bne_n", 32'h00209463, mk(4'd0, 0, 3'd0, 3'd0, 2'd0, S_PCW));
    br_eq = 1'b0;
    run("bne_t", 32'h00209463, mk(4'd0, 0, 3'd0, 3'd2, 2'd0, S_PCW));

    run("jal", 32'h008000EF, mk(4'd0, 0, 3'd0, 3'd3, 2'd0, S_PCW | S_RFW));
    run("unk", 32'h0000007F, mk(4'd0, 0, 3'd0, 3'd0, 2'd0, S_PCW));

    // interrupt requested while ADD executes
    intr = 1'b1; mie = 1'b1;
    run("iadd", 32'h002081B3, mk(4'b0000, 0, 3'd0, 3'd0, 2'd3, S_PCW | S_RFW));
`ifdef OTTER_INTR_EN
    cyc("intr", mk(4'd0, 0, 3'd0, 3'd4, 2'd0, S_PCW | S_INT));
`endif
    // mie clear: EXEC must go straight back to FETCH
    mie = 1'b0;
    run("nmie", 32'h002081B3, mk(4'b0000, 0, 3'd0, 3'd0, 2'd3, S_PCW | S_RFW));
    intr = 1'b0;
    run("post", 32'h40208133, mk(4'b1000, 0, 3'd0, 3'd0, 2'd3, S_PCW | S_RFW));

`ifdef OTTER_INTR_EN
    run("csrrw", 32'h30529073, mk(4'b1001, 0, 3'd0, 3'd0, 2'd1, S_PCW | S_RFW | S_CSR));
    run("mret",  32'h30200073, mk(4'd0, 0, 3'd0, 3'd5, 2'd0, S_PCW | S_MRT));
`else
    run("csrrw", 32'h30529073, mk(4'd0, 0, 3'd0, 3'd0, 2'd0, S_PCW));
    run("mret",  32'h30200073, mk(4'd0, 0, 3'd0, 3'd0, 2'd0, S_PCW));
`endif

    // reset asserted in the middle of a store's EXEC cycle
    ir = 32'h0020A223;
    cyc("sw_fetch", vf);
    chk("sw_exec", obs, mk(4'd0, 0, 3'd2, 3'd0, 2'd0, S_PCW | S_WE2));
    #2 rst_n = 1'b0;
    #1 chk("sw_rst", obs, '0);
    @(posedge clk);
    #1;
    chk("rst_hold", obs, '0);
    rst_n = 1'b1;
    cyc("init2", '0);
    run("add2", 32'h002081B3, mk(4'b0000, 0, 3'd0, 3'd0, 2'd3, S_PCW | S_RFW));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
